// File: rtl/rv_dff_bank.sv
`default_nettype none
// ============================================================================
//  Module   : rv_dff_bank
//  Purpose  : Parameterized register bank with synchronous active-high reset,
//             global write enable and per-bit write mask. Optional parity
//             protection of the stored value, compiled in by defining the
//             macro RV_DFF_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module rv_dff_bank #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_l,   // active-high synchronous reset
  input  logic             en,
  input  logic [WIDTH-1:0] wmask,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             perr
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] merged;

  // Post-write value: masked-in bits come from din, the rest keep their state.
  always_comb begin
    merged = (din & wmask) | (data_q & ~wmask);
  end

  // Data storage: reset wins over any write on the same edge.
  always_ff @(posedge clk) begin
    if (rst_l) begin
      data_q <= RESET_VAL;
    end else if (en) begin
      data_q <= merged;
    end
  end

  assign dout = data_q;

`ifdef RV_DFF_PARITY_EN
  logic par_q;

  // Hidden parity bit tracks the XOR of every value actually written.
  always_ff @(posedge clk) begin
    if (rst_l) begin
      par_q <= ^RESET_VAL;
    end else if (en) begin
      par_q <= ^merged;
    end
  end

  // Flag an odd number of corrupted stored bits, with no added latency.
  assign perr = (^data_q) ^ par_q;
`else
  assign perr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv_dff_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_dff_bank
//  Purpose  : Directed self-checking bench for rv_dff_bank (8-bit bank with
//             reset value 8'hA5, plus a 168-bit LFSR-style shift usage).
//             Parity steps are included when RV_DFF_PARITY_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv_dff_bank;

  logic         clk = 1'b0;
  int           checks = 0;
  int           errors = 0;

  // 8-bit instance
  logic         rst_8;
  logic         en_8;
  logic [7:0]   wmask_8;
  logic [7:0]   din_8;
  logic [7:0]   dout_8;
  logic         perr_8;

  // 168-bit instance used as a shift register
  logic         rst_w;
  logic         en_w;
  logic [167:0] wmask_w;
  logic [167:0] din_w;
  logic [167:0] dout_w;
  logic         perr_w;

  always #5 clk = ~clk;

  assign din_w = {dout_w[164:0], 3'b101};

  rv_dff_bank #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk   (clk),
    .rst_l (rst_8),
    .en    (en_8),
    .wmask (wmask_8),
    .din   (din_8),
    .dout  (dout_8),
    .perr  (perr_8)
  );

  rv_dff_bank #(.WIDTH(168), .RESET_VAL('0)) dutw (
    .clk   (clk),
    .rst_l (rst_w),
    .en    (en_w),
    .wmask (wmask_w),
    .din   (din_w),
    .dout  (dout_w),
    .perr  (perr_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [167:0] obs, input logic [167:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_8 = 1'b1; en_8 = 1'b1; wmask_8 = 8'hFF; din_8 = 8'hFF;
    rst_w = 1'b1; en_w = 1'b1; wmask_w = '1;

    // Reset with write enabled and all-ones data
    step();
    check("reset_dout", {160'd0, dout_8}, {160'd0, 8'hA5});
    check("reset_perr", {167'd0, perr_8}, 168'd0);
    check("wide_reset", dout_w, 168'd0);

    // Full write, and first LFSR edge
    rst_8 = 1'b0; din_8 = 8'h3C; rst_w = 1'b0;
    step();
    check("full_write", {160'd0, dout_8}, {160'd0, 8'h3C});
    check("lfsr_edge1", {165'd0, dout_w[2:0]}, {165'd0, 3'b101});

    // Second LFSR edge, then freeze the wide bank
    en_8 = 1'b0; din_8 = 8'h00;
    step();
    check("hold_0", {160'd0, dout_8}, {160'd0, 8'h3C});
    check("lfsr_edge2", {162'd0, dout_w[5:0]}, {162'd0, 6'b101101});
    check("lfsr_edge2_full", dout_w, {162'd0, 6'b101101});
    en_w = 1'b0;
    step();
    check("hold_1", {160'd0, dout_8}, {160'd0, 8'h3C});
    check("wide_hold", dout_w, {162'd0, 6'b101101});
    step();
    check("hold_2", {160'd0, dout_8}, {160'd0, 8'h3C});

    // Masked write: low nibble from din, high nibble kept
    en_8 = 1'b1; wmask_8 = 8'h0F; din_8 = 8'hA1;
    step();
    check("masked_lo", {160'd0, dout_8}, {160'd0, 8'h31});

    // Reset overrides a concurrent write
    rst_8 = 1'b1; wmask_8 = 8'hFF; din_8 = 8'h77;
    step();
    check("reset_prio", {160'd0, dout_8}, {160'd0, 8'hA5});
    rst_8 = 1'b0;
    step();
    check("post_reset_write", {160'd0, dout_8}, {160'd0, 8'h77});

    // Hold with mask set but enable low
    en_8 = 1'b0; din_8 = 8'h00;
    step();
    check("en_low_hold", {160'd0, dout_8}, {160'd0, 8'h77});

    // Masked write of the high nibble
    en_8 = 1'b1; wmask_8 = 8'hF0; din_8 = 8'h0F;
    step();
    check("masked_hi", {160'd0, dout_8}, {160'd0, 8'h07});
    check("perr_clean", {167'd0, perr_8}, 168'd0);

`ifdef RV_DFF_PARITY_EN
    wmask_8 = 8'hFF; din_8 = 8'h03;
    step();
    check("par_write", {160'd0, dout_8}, {160'd0, 8'h03});
    check("par_ok", {167'd0, perr_8}, 168'd0);
    en_8 = 1'b0;
    force dut8.data_q = 8'h02;
    #1;
    check("par_corrupt", {167'd0, perr_8}, 168'd1);
    release dut8.data_q;
    en_8 = 1'b1;
    step();
    check("par_rewrite", {160'd0, dout_8}, {160'd0, 8'h03});
    check("par_cleared", {167'd0, perr_8}, 168'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
